// File: rtl/bev_pkg.sv
`default_nettype none
// bev_pkg : shared constants, recipe tables and step search for the beverage dispenser.
// Rev 1.0
package bev_pkg;
   localparam int N_ING    = 5;
   localparam int N_RECIPE = 4;
   localparam int CREDIT_W = 4;
   localparam int DUR_W    = 3;
   localparam int SEL_W    = $clog2(N_RECIPE);
   localparam int STEP_W   = $clog2(N_ING + 1);

   localparam int ING_WATER     = 0;
   localparam int ING_COFFEE    = 1;
   localparam int ING_SUGAR     = 2;
   localparam int ING_MILK      = 3;
   localparam int ING_CHOCOLATE = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DISPENSE = 2'd1,
      DONE     = 2'd2
   } state_e;

   localparam logic [CREDIT_W-1:0] PRICE [N_RECIPE] = '{4'd1, 4'd2, 4'd3, 4'd2};

   localparam logic [DUR_W-1:0] DUR [N_RECIPE][N_ING] = '{
      '{3'd1, 3'd2, 3'd0, 3'd0, 3'd0},
      '{3'd1, 3'd2, 3'd0, 3'd2, 3'd0},
      '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2},
      '{3'd1, 3'd0, 3'd1, 3'd1, 3'd3}
   };

   // Lowest step index >= from with a nonzero duration; N_ING when none remain.
   function automatic logic [STEP_W-1:0] next_step(input logic [SEL_W-1:0] rcp,
                                                   input logic [STEP_W-1:0] from);
      next_step = STEP_W'(N_ING);
      for (int k = N_ING - 1; k >= 0; k--) begin
         if (k >= int'(from) && DUR[rcp][k] != '0) next_step = STEP_W'(k);
      end
   endfunction
endpackage
`default_nettype wire

// File: rtl/beverage_dispenser_ctrl_if.sv
`default_nettype none
// beverage_dispenser_ctrl_if : panel/valve signal bundle between front end and controller.
// Rev 1.0
interface beverage_dispenser_ctrl_if;
   import bev_pkg::*;

   logic                coin_100;
   logic                coin_500;
   logic [SEL_W-1:0]    recipe_sel;
   logic                start;
   logic                cancel;
   logic [CREDIT_W-1:0] credit;
   logic [CREDIT_W-1:0] change;
   logic                change_valid;
   logic [N_ING-1:0]    ingredient;
   logic                busy;
   logic                finished;
   logic                error;

   modport master (
      output coin_100, coin_500, recipe_sel, start, cancel,
      input  credit, change, change_valid, ingredient, busy, finished, error
   );

   modport slave (
      input  coin_100, coin_500, recipe_sel, start, cancel,
      output credit, change, change_valid, ingredient, busy, finished, error
   );
endinterface
`default_nettype wire

// File: rtl/dispense_step_timer.sv
`default_nettype none
// dispense_step_timer : prescaler plus second counter; pulses done after dur seconds from load.
// Rev 1.0
module dispense_step_timer #(
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int DUR_W         = 3
) (
   input  wire logic             clock,
   input  wire logic             reset,
   input  wire logic             load,
   input  wire logic [DUR_W-1:0] dur,
   output logic                  done
);
   localparam int CYC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

   logic [CYC_W-1:0] r_cyc;
   logic [DUR_W-1:0] r_sec;
   logic [DUR_W-1:0] r_dur;
   logic             r_run;
   logic             w_sec_end;

   assign w_sec_end = (r_cyc == CYC_W'(TICKS_PER_SEC - 1));
   assign done      = r_run && w_sec_end && (r_sec == r_dur - DUR_W'(1));

   // Counters restart on every load so step boundaries never accumulate drift.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cyc <= '0;
         r_sec <= '0;
         r_dur <= '0;
         r_run <= 1'b0;
      end else if (load) begin
         r_cyc <= '0;
         r_sec <= '0;
         r_dur <= dur;
         r_run <= (dur != '0);
      end else if (r_run) begin
         if (done) begin
            r_run <= 1'b0;
         end
         if (w_sec_end) begin
            r_cyc <= '0;
            r_sec <= r_sec + DUR_W'(1);
         end else begin
            r_cyc <= r_cyc + CYC_W'(1);
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/beverage_dispenser_ctrl.sv
`default_nettype none
// beverage_dispenser_ctrl : coin credit, recipe price check, timed valve sequencing and change return.
// Rev 1.0
module beverage_dispenser_ctrl
   import bev_pkg::*;
#(
   parameter int TICKS_PER_SEC = 50_000_000
) (
   input wire logic                   clock,
   input wire logic                   reset,
   beverage_dispenser_ctrl_if.slave   bus
);
   localparam logic [1:0] ST_IDLE     = IDLE;
   localparam logic [1:0] ST_DISPENSE = DISPENSE;
   localparam logic [1:0] ST_DONE     = DONE;
   localparam int         SUM_W       = CREDIT_W + 2;

   logic [1:0]          r_state;
   logic [CREDIT_W-1:0] r_credit;
   logic [CREDIT_W-1:0] r_change;
   logic                r_change_valid;
   logic                r_finished;
   logic                r_error;
   logic [SEL_W-1:0]    r_recipe;
   logic [STEP_W-1:0]   r_step;

   logic [SUM_W-1:0]    w_sum;
   logic [CREDIT_W-1:0] w_credit_nxt;
   logic                w_short;
   logic [STEP_W-1:0]   w_first;
   logic [STEP_W-1:0]   w_next;
   logic                w_load;
   logic [DUR_W-1:0]    w_dur;
   logic                w_done;

   assign w_sum = SUM_W'(r_credit) + SUM_W'(bus.coin_100) + (bus.coin_500 ? SUM_W'(5) : '0);
   assign w_credit_nxt = (w_sum > SUM_W'({CREDIT_W{1'b1}})) ? '1 : w_sum[CREDIT_W-1:0];
   assign w_short = (r_credit < PRICE[bus.recipe_sel]);
   assign w_first = next_step(bus.recipe_sel, '0);
   assign w_next  = next_step(r_recipe, r_step + STEP_W'(1));

   always_comb begin
      w_load = 1'b0;
      w_dur  = '0;
      if (r_state == ST_IDLE && !bus.cancel && bus.start && !w_short && w_first != STEP_W'(N_ING)) begin
         w_load = 1'b1;
         w_dur  = DUR[bus.recipe_sel][w_first];
      end else if (r_state == ST_DISPENSE && w_done && w_next != STEP_W'(N_ING)) begin
         w_load = 1'b1;
         w_dur  = DUR[r_recipe][w_next];
      end
   end

   dispense_step_timer #(
      .TICKS_PER_SEC (TICKS_PER_SEC),
      .DUR_W         (DUR_W)
   ) u_timer (
      .clock (clock),
      .reset (reset),
      .load  (w_load),
      .dur   (w_dur),
      .done  (w_done)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_credit       <= '0;
         r_change       <= '0;
         r_change_valid <= 1'b0;
         r_finished     <= 1'b0;
         r_error        <= 1'b0;
         r_recipe       <= '0;
         r_step         <= '0;
      end else begin
         r_change_valid <= 1'b0;
         r_finished     <= 1'b0;
         r_error        <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // Cancel always shadows start, even when there is nothing to refund.
               if (bus.cancel) begin
                  if (r_credit != '0) begin
                     r_change       <= r_credit;
                     r_change_valid <= 1'b1;
                     r_credit       <= '0;
                  end else begin
                     r_credit       <= w_credit_nxt;
                  end
               end else if (bus.start) begin
                  if (w_short) begin
                     r_error <= 1'b1;
                  end else begin
                     r_recipe <= bus.recipe_sel;
                     r_change <= r_credit - PRICE[bus.recipe_sel];
                     r_credit <= '0;
                     if (w_first == STEP_W'(N_ING)) begin
                        r_state        <= ST_DONE;
                        r_finished     <= 1'b1;
                        r_change_valid <= 1'b1;
                     end else begin
                        r_state <= ST_DISPENSE;
                        r_step  <= w_first;
                     end
                  end
               end else begin
                  r_credit <= w_credit_nxt;
               end
            end
            ST_DISPENSE: begin
               if (w_done) begin
                  if (w_next == STEP_W'(N_ING)) begin
                     r_state        <= ST_DONE;
                     r_finished     <= 1'b1;
                     r_change_valid <= 1'b1;
                  end else begin
                     r_step <= w_next;
                  end
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.credit       = r_credit;
   assign bus.change       = r_change;
   assign bus.change_valid = r_change_valid;
   assign bus.finished     = r_finished;
   assign bus.error        = r_error;
   assign bus.busy         = (r_state != ST_IDLE);
   assign bus.ingredient   = (r_state == ST_DISPENSE) ? (N_ING'(1) << r_step) : '0;
endmodule
`default_nettype wire

// File: tb/tb_beverage_dispenser_ctrl.sv
`default_nettype none
// tb_beverage_dispenser_ctrl : scoreboard bench for the dispenser at four ticks per second.
// Rev 1.0
module tb_beverage_dispenser_ctrl;
   localparam int K_RUN = 1;
   localparam int K_CHG = 2;
   localparam int K_ERR = 3;
   localparam int K_FIN = 4;

   typedef struct {
      int kind;
      int a;
      int b;
   } ev_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   ev_t  q[$];

   beverage_dispenser_ctrl_if bus ();

   beverage_dispenser_ctrl #(.TICKS_PER_SEC(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push(input int kind, input int a, input int b);
      ev_t e;
      e.kind = kind;
      e.a    = a;
      e.b    = b;
      q.push_back(e);
   endtask

   task automatic emit(input int kind, input int a, input int b);
      ev_t e;
      if (q.size() == 0) begin
         chk("unexpected_event_kind", kind, 0);
      end else begin
         e = q.pop_front();
         chk("event_kind", kind, e.kind);
         chk("event_a", a, e.a);
         chk("event_b", b, e.b);
      end
   endtask

   // Output monitor: turns valve runs and strobes into events for the scoreboard.
   int cur_ing = 0;
   int run_len = 0;
   always @(negedge clock) begin
      if (reset) begin
         cur_ing = 0;
         run_len = 0;
      end else begin
         if (int'(bus.ingredient) != cur_ing) begin
            if (cur_ing != 0) emit(K_RUN, cur_ing, run_len);
            cur_ing = int'(bus.ingredient);
            run_len = (cur_ing != 0) ? 1 : 0;
         end else if (cur_ing != 0) begin
            run_len++;
         end
         if (bus.change_valid)  emit(K_CHG, int'(bus.change), int'(bus.finished));
         else if (bus.finished) emit(K_FIN, 0, 0);
         if (bus.error)         emit(K_ERR, int'(bus.credit), int'(bus.busy));
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_coin(input logic c100, input logic c500);
      bus.coin_100 = c100;
      bus.coin_500 = c500;
      tick();
      bus.coin_100 = 1'b0;
      bus.coin_500 = 1'b0;
   endtask

   task automatic pulse_start(input int sel, input logic with_cancel);
      bus.recipe_sel = 2'(sel);
      bus.start      = 1'b1;
      bus.cancel     = with_cancel;
      tick();
      bus.start      = 1'b0;
      bus.cancel     = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      while ((bus.busy || q.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) chk({tag, "_timeout"}, 1, 0);
      tick();
   endtask

   initial begin
      bus.coin_100   = 1'b0;
      bus.coin_500   = 1'b0;
      bus.recipe_sel = '0;
      bus.start      = 1'b0;
      bus.cancel     = 1'b0;
      tick();
      tick();
      chk("rst_credit", bus.credit, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_ingredient", bus.ingredient, 0);
      chk("rst_change_valid", bus.change_valid, 0);
      reset = 1'b0;
      tick();

      // Espresso with change.
      pulse_coin(1'b0, 1'b1);
      chk("esp_credit", bus.credit, 5);
      push(K_RUN, 1, 4);
      push(K_RUN, 2, 8);
      push(K_CHG, 4, 1);
      pulse_start(0, 1'b0);
      chk("esp_busy", bus.busy, 1);
      chk("esp_credit_cleared", bus.credit, 0);
      wait_idle("esp", 60);
      chk("esp_credit_end", bus.credit, 0);

      // Insufficient credit, then refund.
      pulse_coin(1'b1, 1'b0);
      chk("short_credit", bus.credit, 1);
      push(K_ERR, 1, 0);
      pulse_start(2, 1'b0);
      chk("short_busy", bus.busy, 0);
      chk("short_credit_kept", bus.credit, 1);
      push(K_CHG, 1, 0);
      bus.cancel = 1'b1;
      tick();
      bus.cancel = 1'b0;
      tick();
      chk("refund_credit", bus.credit, 0);

      // Chocolate: coffee skipped, coins lost while busy.
      repeat (3) pulse_coin(1'b1, 1'b0);
      chk("choc_credit", bus.credit, 3);
      push(K_RUN, 1, 4);
      push(K_RUN, 4, 4);
      push(K_RUN, 8, 4);
      push(K_RUN, 16, 12);
      push(K_CHG, 1, 1);
      pulse_start(3, 1'b0);
      repeat (5) tick();
      pulse_coin(1'b0, 1'b1);
      chk("choc_coin_lost", bus.credit, 0);
      wait_idle("choc", 80);
      chk("choc_credit_end", bus.credit, 0);

      // Simultaneous coins and saturation.
      pulse_coin(1'b1, 1'b1);
      chk("both_coins", bus.credit, 6);
      pulse_coin(1'b0, 1'b1);
      chk("coin_11", bus.credit, 11);
      pulse_coin(1'b0, 1'b1);
      chk("saturated", bus.credit, 15);
      push(K_CHG, 15, 0);
      bus.cancel = 1'b1;
      tick();
      bus.cancel = 1'b0;
      tick();

      // Start with cancel in the same cycle is a refund only.
      repeat (2) pulse_coin(1'b1, 1'b0);
      push(K_CHG, 2, 0);
      pulse_start(0, 1'b1);
      chk("prio_busy", bus.busy, 0);
      tick();
      chk("prio_credit", bus.credit, 0);
      chk("prio_no_brew", bus.ingredient, 0);

      // Mocha aborted by reset during milk.
      repeat (3) pulse_coin(1'b1, 1'b0);
      push(K_RUN, 1, 4);
      push(K_RUN, 2, 4);
      push(K_RUN, 4, 4);
      pulse_start(2, 1'b0);
      begin
         int n;
         n = 0;
         while (bus.ingredient != 5'b01000 && n < 40) begin
            tick();
            n++;
         end
         if (n >= 40) chk("mocha_milk_timeout", 1, 0);
      end
      tick();
      reset = 1'b1;
      tick();
      chk("abort_ingredient", bus.ingredient, 0);
      chk("abort_busy", bus.busy, 0);
      chk("abort_change_valid", bus.change_valid, 0);
      chk("abort_finished", bus.finished, 0);
      chk("abort_credit", bus.credit, 0);
      chk("abort_change", bus.change, 0);
      reset = 1'b0;
      repeat (4) tick();
      chk("queue_drained", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout observed 1 expected 0");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
